// File: rtl/cfg_arb_pkg.sv
// Types and sizing helpers for config_req_arbiter and its picker.
package cfg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } arb_state_e;

  localparam int unsigned CNT_W_MIN = 8;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned cnt_w(input int unsigned t);
    return ($clog2(t) > CNT_W_MIN) ? $clog2(t) : CNT_W_MIN;
  endfunction

endpackage

// File: rtl/config_pkg.sv
// Shared configuration-bus type definitions for the cohort tile register path.
package config_pkg;

  typedef enum logic [1:0] {
    T_LOAD  = 2'd0,
    T_STORE = 2'd1
  } config_type_t;

endpackage

// File: rtl/config_if.sv
// Uncached configuration register bus: one request channel, one read-return channel.
interface config_if
  import config_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64
);

  logic               valid;
  config_type_t       config_type;
  logic [ADDR_W-1:0]  addr;
  logic [DATA_W-1:0]  data;
  logic               read_valid;
  logic [DATA_W-1:0]  read_data;

  modport master (output valid, config_type, addr, data, input read_valid, read_data);
  modport slave  (input valid, config_type, addr, data, output read_valid, read_data);

endinterface

// File: rtl/cfg_rr_picker.sv
// Combinational rotating-priority picker: first request after ptr_i, wrapping.
module cfg_rr_picker
  import cfg_arb_pkg::*;
#(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned PTR_W = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [PTR_W-1:0] idx_o,
  output logic             any_o
);

  int unsigned idx;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(ptr_i) + k) % N_REQ;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        idx_o      = PTR_W'(idx);
      end
    end
  end

endmodule

// File: rtl/config_req_arbiter.sv
// Round-robin arbiter sharing one config_if master among N_REQ requesters.
// Optional load timeout enabled by defining CFG_ARB_TIMEOUT_EN.
module config_req_arbiter
  import cfg_arb_pkg::*, config_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [N_REQ-1:0]               req_valid_i,
  input  config_type_t [N_REQ-1:0]       req_type_i,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr_i,
  input  logic [N_REQ-1:0][DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]               req_ready_o,
  output logic [N_REQ-1:0]               rsp_valid_o,
  output logic [DATA_W-1:0]              rsp_data_o,
  output logic                           rsp_err_o,
  config_if.master                       conf
);

  localparam int unsigned PTR_W = ptr_w(N_REQ);

  if (N_REQ < 2 || TIMEOUT < 2) begin : g_bad_cfg
    $error("config_req_arbiter: N_REQ and TIMEOUT must both be at least 2");
  end

  arb_state_e         state_q;
  logic [PTR_W-1:0]   rr_ptr_q;
  logic [PTR_W-1:0]   gidx_q;
  config_type_t       type_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;

  logic [N_REQ-1:0]   pick_gnt;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic               tmo;

  cfg_rr_picker #(.N_REQ(N_REQ)) u_picker (
    .req_i (req_valid_i),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign req_ready_o      = (rst_n && state_q == IDLE) ? pick_gnt : '0;
  assign rsp_data_o       = rdata_q;
  assign conf.valid       = (state_q == ISSUE) || (state_q == WAIT);
  assign conf.config_type = type_q;
  assign conf.addr        = addr_q;
  assign conf.data        = wdata_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= PTR_W'(N_REQ - 1);
      gidx_q      <= '0;
      type_q      <= T_LOAD;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      rsp_valid_o <= '0;
    end else begin
      rsp_valid_o <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gidx_q   <= pick_idx;
            rr_ptr_q <= pick_idx;
            type_q   <= req_type_i[pick_idx];
            addr_q   <= req_addr_i[pick_idx];
            wdata_q  <= req_data_i[pick_idx];
            rdata_q  <= '0;
            state_q  <= ISSUE;
          end
        end
        // ISSUE and WAIT share one exit test; a store never reaches WAIT.
        ISSUE, WAIT: begin
          if (type_q != T_LOAD) begin
            state_q     <= RESP;
            rsp_valid_o <= N_REQ'(1) << gidx_q;
          end else if (conf.read_valid) begin
            rdata_q     <= conf.read_data;
            state_q     <= RESP;
            rsp_valid_o <= N_REQ'(1) << gidx_q;
          end else if (tmo) begin
            rdata_q     <= '0;
            state_q     <= RESP;
            rsp_valid_o <= N_REQ'(1) << gidx_q;
          end else begin
            state_q <= WAIT;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef CFG_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = cnt_w(TIMEOUT);

  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  assign tmo       = (cnt_q == CNT_W'(TIMEOUT - 1));
  assign rsp_err_o = err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
      if (pick_any) err_q <= 1'b0;
    end else if (state_q == ISSUE || state_q == WAIT) begin
      cnt_q <= cnt_q + 1'b1;
      if (type_q == T_LOAD && !conf.read_valid && tmo) err_q <= 1'b1;
    end
  end
`else
  assign tmo       = 1'b0;
  assign rsp_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_config_req_arbiter.sv
// Scoreboard bench for config_req_arbiter: random requesters, latency-programmable slave,
// rotation/latency model; covers the timeout path when CFG_ARB_TIMEOUT_EN is defined.
module tb_config_req_arbiter;
  import config_pkg::*;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;
`ifdef CFG_ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]               req_valid = '0;
  config_type_t [N-1:0]       req_type;
  logic [N-1:0][AW-1:0]       req_addr = '0;
  logic [N-1:0][DW-1:0]       req_data = '0;
  logic [N-1:0]               req_ready;
  logic [N-1:0]               rsp_valid;
  logic [DW-1:0]              rsp_data;
  logic                       rsp_err;

  config_if #(.ADDR_W(AW), .DATA_W(DW)) conf_bus ();

  config_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid),
    .req_type_i  (req_type),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .conf        (conf_bus)
  );

  typedef struct {
    int              g;
    bit              load;
    config_type_t    typ;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW-1:0]   rdata;
    int              lat;
    longint          acc;
    longint          last_issue;
    longint          due;
    bit              err;
    logic [DW-1:0]   exp_data;
  } txn_t;

  txn_t          expq[$];
  txn_t          cur;
  bit            busy = 1'b0;
  int            last = N - 1;
  int            force_lat = -1;
  bit            has_frd = 1'b0;
  logic [DW-1:0] frd = '0;
  logic [N-1:0]  acked = '0;
  longint        cyc = 0;
  int            rst_edges = 0;
  int            tests = 0;
  int            fails = 0;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // Reference rotation: first pending requester after the last one granted.
  function automatic int pick();
    for (int k = 1; k <= N; k++)
      if (req_valid[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic void accept(input int g);
    cur.g     = g;
    cur.typ   = req_type[g];
    cur.load  = (req_type[g] == T_LOAD);
    cur.addr  = req_addr[g];
    cur.wdata = req_data[g];
    cur.lat   = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 7));
    force_lat = -1;
    cur.rdata = has_frd ? frd : {$urandom, $urandom};
    has_frd   = 1'b0;
    cur.acc   = cyc;
    cur.err   = 1'b0;
    busy      = 1'b1;
    last      = g;
    acked[g]  = 1'b1;
    if (!cur.load) begin
      cur.last_issue = cyc + 1;
      cur.due        = cyc + 2;
      cur.exp_data   = '0;
      expq.push_back(cur);
    end else if (TMO_ON && cur.lat >= TMO) begin
      cur.last_issue = cyc + TMO;
      cur.due        = cyc + TMO + 1;
      cur.exp_data   = '0;
      cur.err        = 1'b1;
      expq.push_back(cur);
    end else if (cur.lat == NEVER) begin
      cur.last_issue = cyc + 100000;
      cur.due        = cyc + 100000;
    end else begin
      cur.last_issue = cyc + 1 + cur.lat;
      cur.due        = cyc + 2 + cur.lat;
      cur.exp_data   = cur.rdata;
      expq.push_back(cur);
    end
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) rst_edges++;
    else        rst_edges = 0;
  end

  initial begin
    conf_bus.read_valid = 1'b0;
    conf_bus.read_data  = '0;
  end

  // Monitor, slave model and scoreboard, all sampled on the falling edge.
  always @(negedge clk) begin
    int         eg;
    logic [N-1:0] exp_rdy;
    bit         expv;
    txn_t       e;
    if (!rst_n) begin
      if (rst_edges > 0) begin
        chk("rst_req_ready",  64'(req_ready), 64'(0));
        chk("rst_rsp_valid",  64'(rsp_valid), 64'(0));
        chk("rst_conf_valid", 64'(conf_bus.valid), 64'(0));
        chk("rst_rsp_err",    64'(rsp_err), 64'(0));
      end
      busy = 1'b0;
      last = N - 1;
      expq.delete();
      conf_bus.read_valid = 1'b0;
    end else begin
      eg      = busy ? -1 : pick();
      exp_rdy = (eg < 0) ? '0 : (N'(1) << eg);
      chk("grant", 64'(req_ready), 64'(exp_rdy));
      if (eg >= 0 && req_ready == exp_rdy) accept(eg);

      expv = busy && (cyc >= cur.acc + 1) && (cyc <= cur.last_issue);
      chk("conf_valid", 64'(conf_bus.valid), 64'(expv));
      if (expv && conf_bus.valid) begin
        chk("conf_addr", 64'(conf_bus.addr), 64'(cur.addr));
        chk("conf_type", 64'(conf_bus.config_type), 64'(cur.typ));
        chk("conf_data", conf_bus.data, cur.wdata);
      end
      if (busy && cur.load && cur.lat != NEVER && cyc == cur.acc + 1 + cur.lat) begin
        conf_bus.read_valid = 1'b1;
        conf_bus.read_data  = cur.rdata;
      end else begin
        conf_bus.read_valid = 1'b0;
        conf_bus.read_data  = {$urandom, $urandom};
      end

      if (rsp_valid != '0) begin
        if (expq.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 64'(0));
        end else begin
          e = expq.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'(N'(1) << e.g));
          chk("rsp_data",  rsp_data, e.exp_data);
          chk("rsp_err",   64'(rsp_err), 64'(e.err));
          chk("rsp_cycle", 64'(cyc), 64'(e.due));
          busy = 1'b0;
        end
      end else if (expq.size() > 0 && cyc > expq[0].due) begin
        e = expq.pop_front();
        chk("rsp_missing", 64'(rsp_valid), 64'(N'(1) << e.g));
        busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acked[i]) begin
        req_valid[i] = 1'b0;
        acked[i]     = 1'b0;
      end
  endtask

  task automatic raise(input int i, input bit ld, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_type[i]  = ld ? T_LOAD : T_STORE;
    req_addr[i]  = a;
    req_data[i]  = d;
    req_valid[i] = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || req_valid != '0) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) begin
      tests++;
      fails++;
      $display("FAIL idle_wait: still busy after %0d cycles, required idle", n);
    end
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) req_type[i] = T_STORE;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single store, requester 0.
    raise(0, 1'b0, 32'h08, 64'hA5);
    wait_idle();

    // Load answered in the ISSUE cycle.
    force_lat = 0; has_frd = 1'b1; frd = 64'h1234;
    raise(2, 1'b1, 32'h10, '0);
    wait_idle();

    // Load answered after five wait cycles.
    force_lat = 5;
    raise(1, 1'b1, 32'h20, '0);
    wait_idle();

    // All requesters hold valid: strict rotation.
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (!req_valid[i]) raise(i, 1'b0, 32'(i * 8), 64'(c));
    end
    wait_idle();

    // Random traffic with occasional withdrawn requests.
    for (int c = 0; c < 400; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 3) == 0)
          raise(i, 1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom});
        else if (req_valid[i] && $urandom_range(0, 31) == 0)
          req_valid[i] = 1'b0;
      end
    end
    wait_idle();

    // Reset while a load is waiting, then a fresh load.
    force_lat = NEVER;
    raise(3, 1'b1, 32'h30, '0);
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    raise(3, 1'b1, 32'h34, '0);
    wait_idle();

    // Slave never answers: timeout error, or an indefinitely held request.
    force_lat = NEVER;
    raise(1, 1'b1, 32'h40, '0);
    if (TMO_ON) begin
      wait_idle();
    end else begin
      repeat (25) tick();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
    end

    // Response in the last cycle before the timeout would fire.
    force_lat = TMO - 1;
    raise(0, 1'b1, 32'h50, '0);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
